// File: rtl/csr_reg_responder.sv
// rtl/csr_reg_responder.sv - HyperCoreX CSR register file with a registered request/response port.
// Optional: define CSR_ADDR_ERR_EN to add csr_rsp_err_o (out-of-range address or write to RO reg 7/8).
module csr_reg_responder #(
  parameter int CsrDataWidth     = 32,
  parameter int CsrAddrWidth     = 32,
  parameter int InstMemAddrWidth = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [CsrAddrWidth-1:0]     csr_req_addr_i,
  input  logic [CsrDataWidth-1:0]     csr_req_data_i,
  input  logic                        csr_req_write_i,
  input  logic                        csr_req_valid_i,
  output logic                        csr_req_ready_o,
  output logic [CsrDataWidth-1:0]     csr_rsp_data_o,
  output logic                        csr_rsp_valid_o,
  input  logic                        csr_rsp_ready_i,
  input  logic                        core_busy_i,
  input  logic [7:0]                  am_predict_i,
  input  logic                        am_predict_valid_i,
  input  logic [InstMemAddrWidth-1:0] inst_pc_i,
  input  logic [CsrDataWidth-1:0]     inst_at_addr_i,
  output logic                        start_core_o,
  output logic                        core_clr_o,
  output logic                        inst_clr_o,
  output logic                        seq_test_o,
  output logic [1:0]                  ima_mux_o,
  output logic                        imb_mux_o,
  output logic [CsrDataWidth-1:0]     am_num_predict_o,
  output logic                        inst_wr_mode_o,
  output logic                        inst_dbg_mode_o,
  output logic [InstMemAddrWidth-1:0] inst_wr_addr_o,
  output logic [CsrDataWidth-1:0]     inst_wr_data_o,
  output logic                        inst_wr_en_o,
  output logic [InstMemAddrWidth-1:0] inst_rddbg_addr_o,
  output logic [1:0]                  loop_mode_o,
  output logic [23:0]                 loop_jump_o,
  output logic [23:0]                 loop_end_o,
  output logic [23:0]                 loop_count_o,
  output logic [CsrDataWidth-1:0]     slice_mode_o,
  output logic [CsrDataWidth-1:0]     slice_num_elem_o,
  output logic [CsrDataWidth-1:0]     observable_o
`ifdef CSR_ADDR_ERR_EN
  ,
  output logic                        csr_rsp_err_o
`endif
);

  logic                        r_rsp_valid;
  logic [CsrDataWidth-1:0]     r_rsp_data;
  logic                        r_start;
  logic                        r_core_clr;
  logic                        r_inst_clr;
  logic                        r_inst_wr_en;
  logic                        r_seq_test;
  logic [1:0]                  r_ima_mux;
  logic                        r_imb_mux;
  logic [CsrDataWidth-1:0]     r_am_num_predict;
  logic [7:0]                  r_am_data;
  logic                        r_am_flag;
  logic                        r_inst_wr_mode;
  logic                        r_inst_dbg_mode;
  logic [InstMemAddrWidth-1:0] r_inst_wr_addr;
  logic [CsrDataWidth-1:0]     r_inst_wr_data;
  logic [InstMemAddrWidth-1:0] r_inst_rddbg_addr;
  logic [1:0]                  r_loop_mode;
  logic [23:0]                 r_loop_jump;
  logic [23:0]                 r_loop_end;
  logic [23:0]                 r_loop_count;
  logic [CsrDataWidth-1:0]     r_slice_mode;
  logic [CsrDataWidth-1:0]     r_slice_num_elem;
  logic [CsrDataWidth-1:0]     r_observable;

  logic                        w_accept;
  logic                        w_in_range;
  logic                        w_wr;
  logic                        w_rd;
  logic [3:0]                  w_idx;
  logic [15:0]                 w_we;
  logic [CsrDataWidth-1:0]     w_rdata;

  // A new request may enter in the same cycle the previous response is consumed.
  assign csr_req_ready_o = ~r_rsp_valid | csr_rsp_ready_i;
  assign w_accept        = csr_req_valid_i & csr_req_ready_o;
  assign w_in_range      = ~|csr_req_addr_i[CsrAddrWidth-1:4];
  assign w_idx           = csr_req_addr_i[3:0];
  assign w_wr            = w_accept & csr_req_write_i & w_in_range;
  assign w_rd            = w_accept & ~csr_req_write_i & w_in_range;
  assign w_we            = w_wr ? (16'h0001 << w_idx) : 16'h0000;

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      4'd0:    w_rdata = CsrDataWidth'({r_imb_mux, r_ima_mux, r_seq_test, core_busy_i, 1'b0});
      4'd1:    w_rdata = r_am_num_predict;
      4'd2:    w_rdata = CsrDataWidth'({r_am_flag, r_am_data});
      4'd3:    w_rdata = CsrDataWidth'({r_inst_dbg_mode, r_inst_wr_mode});
      4'd4:    w_rdata = CsrDataWidth'(r_inst_wr_addr);
      4'd5:    w_rdata = r_inst_wr_data;
      4'd6:    w_rdata = CsrDataWidth'(r_inst_rddbg_addr);
      4'd7:    w_rdata = CsrDataWidth'(inst_pc_i);
      4'd8:    w_rdata = inst_at_addr_i;
      4'd9:    w_rdata = CsrDataWidth'(r_loop_mode);
      4'd10:   w_rdata = CsrDataWidth'(r_loop_jump);
      4'd11:   w_rdata = CsrDataWidth'(r_loop_end);
      4'd12:   w_rdata = CsrDataWidth'(r_loop_count);
      4'd13:   w_rdata = r_slice_mode;
      4'd14:   w_rdata = r_slice_num_elem;
      4'd15:   w_rdata = r_observable;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid       <= 1'b0;
      r_rsp_data        <= '0;
      r_start           <= 1'b0;
      r_core_clr        <= 1'b0;
      r_inst_clr        <= 1'b0;
      r_inst_wr_en      <= 1'b0;
      r_seq_test        <= 1'b0;
      r_ima_mux         <= 2'b00;
      r_imb_mux         <= 1'b0;
      r_am_num_predict  <= '0;
      r_am_data         <= 8'h00;
      r_am_flag         <= 1'b0;
      r_inst_wr_mode    <= 1'b0;
      r_inst_dbg_mode   <= 1'b0;
      r_inst_wr_addr    <= '0;
      r_inst_wr_data    <= '0;
      r_inst_rddbg_addr <= '0;
      r_loop_mode       <= 2'b00;
      r_loop_jump       <= 24'h0;
      r_loop_end        <= 24'h0;
      r_loop_count      <= 24'h0;
      r_slice_mode      <= '0;
      r_slice_num_elem  <= '0;
      r_observable      <= '0;
    end else begin
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_rd ? w_rdata : '0;
      end else if (csr_rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
        r_rsp_data  <= '0;
      end

      r_start      <= w_we[0] & csr_req_data_i[0] & ~core_busy_i;
      r_core_clr   <= w_we[0] & csr_req_data_i[6];
      r_inst_clr   <= w_we[3] & csr_req_data_i[2];
      r_inst_wr_en <= w_we[5] & r_inst_wr_mode;

      // The address advances the cycle after each enabled write; explicit loads win.
      if (w_we[4]) begin
        r_inst_wr_addr <= csr_req_data_i[InstMemAddrWidth-1:0];
      end else if (w_we[3] & csr_req_data_i[2]) begin
        r_inst_wr_addr <= '0;
      end else if (r_inst_wr_en) begin
        r_inst_wr_addr <= r_inst_wr_addr + 1'b1;
      end

      if (am_predict_valid_i) begin
        r_am_data <= am_predict_i;
        r_am_flag <= 1'b1;
      end else if (w_rd && w_idx == 4'd2) begin
        r_am_flag <= 1'b0;
      end

      if (w_we[0]) begin
        r_seq_test <= csr_req_data_i[2];
        r_ima_mux  <= csr_req_data_i[4:3];
        r_imb_mux  <= csr_req_data_i[5];
      end
      if (w_we[1]) r_am_num_predict <= csr_req_data_i;
      if (w_we[3]) begin
        r_inst_wr_mode  <= csr_req_data_i[0];
        r_inst_dbg_mode <= csr_req_data_i[1];
      end
      if (w_we[5])  r_inst_wr_data    <= csr_req_data_i;
      if (w_we[6])  r_inst_rddbg_addr <= csr_req_data_i[InstMemAddrWidth-1:0];
      if (w_we[9])  r_loop_mode       <= csr_req_data_i[1:0];
      if (w_we[10]) r_loop_jump       <= csr_req_data_i[23:0];
      if (w_we[11]) r_loop_end        <= csr_req_data_i[23:0];
      if (w_we[12]) r_loop_count      <= csr_req_data_i[23:0];
      if (w_we[13]) r_slice_mode      <= csr_req_data_i;
      if (w_we[14]) r_slice_num_elem  <= csr_req_data_i;
      if (w_we[15]) r_observable      <= csr_req_data_i;
    end
  end

`ifdef CSR_ADDR_ERR_EN
  logic r_rsp_err;
  logic w_err;

  assign w_err = ~w_in_range | (csr_req_write_i & ((w_idx == 4'd7) | (w_idx == 4'd8)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_err <= 1'b0;
    end else if (w_accept) begin
      r_rsp_err <= w_err;
    end else if (csr_rsp_ready_i) begin
      r_rsp_err <= 1'b0;
    end
  end

  assign csr_rsp_err_o = r_rsp_err;
`endif

  assign csr_rsp_valid_o   = r_rsp_valid;
  assign csr_rsp_data_o    = r_rsp_data;
  assign start_core_o      = r_start;
  assign core_clr_o        = r_core_clr;
  assign inst_clr_o        = r_inst_clr;
  assign seq_test_o        = r_seq_test;
  assign ima_mux_o         = r_ima_mux;
  assign imb_mux_o         = r_imb_mux;
  assign am_num_predict_o  = r_am_num_predict;
  assign inst_wr_mode_o    = r_inst_wr_mode;
  assign inst_dbg_mode_o   = r_inst_dbg_mode;
  assign inst_wr_addr_o    = r_inst_wr_addr;
  assign inst_wr_data_o    = r_inst_wr_data;
  assign inst_wr_en_o      = r_inst_wr_en;
  assign inst_rddbg_addr_o = r_inst_rddbg_addr;
  assign loop_mode_o       = r_loop_mode;
  assign loop_jump_o       = r_loop_jump;
  assign loop_end_o        = r_loop_end;
  assign loop_count_o      = r_loop_count;
  assign slice_mode_o      = r_slice_mode;
  assign slice_num_elem_o  = r_slice_num_elem;
  assign observable_o      = r_observable;

endmodule

// File: tb/tb_csr_reg_responder.sv
// tb/tb_csr_reg_responder.sv - scoreboard bench for csr_reg_responder against a register-map model.
`timescale 1ns/1ps
module tb_csr_reg_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        req_write = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b1;
  logic        busy = 1'b0;
  logic [7:0]  am_pred = '0;
  logic        am_valid = 1'b0;
  logic [7:0]  pc = '0;
  logic [31:0] iat = '0;

  logic        req_ready, rsp_valid, start_core, core_clr, inst_clr, seq_test, imb_mux;
  logic        inst_wr_mode, inst_dbg_mode, inst_wr_en;
  logic [31:0] rsp_data, am_num_predict, inst_wr_data, slice_mode, slice_num_elem, observable;
  logic [1:0]  ima_mux, loop_mode;
  logic [7:0]  inst_wr_addr, inst_rddbg_addr;
  logic [23:0] loop_jump, loop_end, loop_count;
`ifdef CSR_ADDR_ERR_EN
  logic        rsp_err;
`endif

  csr_reg_responder dut (
    .clk_i(clk), .rst_i(rst),
    .csr_req_addr_i(req_addr), .csr_req_data_i(req_data), .csr_req_write_i(req_write),
    .csr_req_valid_i(req_valid), .csr_req_ready_o(req_ready),
    .csr_rsp_data_o(rsp_data), .csr_rsp_valid_o(rsp_valid), .csr_rsp_ready_i(rsp_ready),
    .core_busy_i(busy), .am_predict_i(am_pred), .am_predict_valid_i(am_valid),
    .inst_pc_i(pc), .inst_at_addr_i(iat),
    .start_core_o(start_core), .core_clr_o(core_clr), .inst_clr_o(inst_clr),
    .seq_test_o(seq_test), .ima_mux_o(ima_mux), .imb_mux_o(imb_mux),
    .am_num_predict_o(am_num_predict), .inst_wr_mode_o(inst_wr_mode), .inst_dbg_mode_o(inst_dbg_mode),
    .inst_wr_addr_o(inst_wr_addr), .inst_wr_data_o(inst_wr_data), .inst_wr_en_o(inst_wr_en),
    .inst_rddbg_addr_o(inst_rddbg_addr), .loop_mode_o(loop_mode), .loop_jump_o(loop_jump),
    .loop_end_o(loop_end), .loop_count_o(loop_count), .slice_mode_o(slice_mode),
    .slice_num_elem_o(slice_num_elem), .observable_o(observable)
`ifdef CSR_ADDR_ERR_EN
    , .csr_rsp_err_o(rsp_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: one variable per architectural field, plus pending-response flag.
  logic        m_pend, m_start, m_cclr, m_iclr, m_wen;
  logic        m_seq, m_imb, m_wrmode, m_dbg, m_amf;
  logic [1:0]  m_ima, m_lmode;
  logic [7:0]  m_waddr, m_rdbg, m_amd;
  logic [31:0] m_num, m_wdata, m_smode, m_snum, m_obs;
  logic [23:0] m_ljump, m_lend, m_lcount;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_start = 0; m_cclr = 0; m_iclr = 0; m_wen = 0;
    m_seq = 0; m_imb = 0; m_wrmode = 0; m_dbg = 0; m_amf = 0;
    m_ima = 0; m_lmode = 0; m_waddr = 0; m_rdbg = 0; m_amd = 0;
    m_num = 0; m_wdata = 0; m_smode = 0; m_snum = 0; m_obs = 0;
    m_ljump = 0; m_lend = 0; m_lcount = 0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0:  return (32'(busy) << 1) | (32'(m_seq) << 2) | (32'(m_ima) << 3) | (32'(m_imb) << 5);
      1:  return m_num;
      2:  return 32'(m_amd) + 32'(m_amf) * 256;
      3:  return 32'(m_wrmode) + 32'(m_dbg) * 2;
      4:  return 32'(m_waddr);
      5:  return m_wdata;
      6:  return 32'(m_rdbg);
      7:  return 32'(pc);
      8:  return iat;
      9:  return 32'(m_lmode);
      10: return 32'(m_ljump);
      11: return 32'(m_lend);
      12: return 32'(m_lcount);
      13: return m_smode;
      14: return m_snum;
      15: return m_obs;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic acc, inr, wr, old_wen, old_mode;
    int   idx;
    exp_t e;
    acc      = req_valid && (!m_pend || rsp_ready);
    inr      = (req_addr < 32'd16);
    idx      = int'(req_addr[3:0]);
    wr       = acc && req_write && inr;
    old_wen  = m_wen;
    old_mode = m_wrmode;
    m_start = 0; m_cclr = 0; m_iclr = 0; m_wen = 0;
    if (acc) begin
      e.data = (!req_write && inr) ? model_read(idx) : 32'h0;
      e.err  = !inr || (req_write && (idx == 7 || idx == 8));
      exp_q.push_back(e);
      m_pend = 1;
    end else if (rsp_ready) begin
      m_pend = 0;
    end
    if (am_valid) begin
      m_amd = am_pred;
      m_amf = 1;
    end else if (acc && !req_write && inr && idx == 2) begin
      m_amf = 0;
    end
    if (wr && idx == 4)                    m_waddr = req_data[7:0];
    else if (wr && idx == 3 && req_data[2]) m_waddr = 8'd0;
    else if (old_wen)                       m_waddr = m_waddr + 8'd1;
    if (wr) begin
      case (idx)
        0: begin
          m_start = req_data[0] && !busy;
          m_cclr  = req_data[6];
          m_seq   = req_data[2];
          m_ima   = req_data[4:3];
          m_imb   = req_data[5];
        end
        1: m_num = req_data;
        3: begin
          m_wrmode = req_data[0];
          m_dbg    = req_data[1];
          m_iclr   = req_data[2];
        end
        5: begin
          m_wdata = req_data;
          m_wen   = old_mode;
        end
        6:  m_rdbg   = req_data[7:0];
        9:  m_lmode  = req_data[1:0];
        10: m_ljump  = req_data[23:0];
        11: m_lend   = req_data[23:0];
        12: m_lcount = req_data[23:0];
        13: m_smode  = req_data;
        14: m_snum   = req_data;
        15: m_obs    = req_data;
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
  end

  // Monitor: compares handshake, scoreboard head and all configuration outputs each cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    chk("req_ready", 256'(req_ready), 256'(!m_pend || rsp_ready));
    chk("rsp_valid", 256'(rsp_valid), 256'(m_pend));
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 256'(1), 256'(0));
      end else begin
        e = exp_q[0];
        chk("rsp_data", 256'(rsp_data), 256'(e.data));
`ifdef CSR_ADDR_ERR_EN
        chk("rsp_err", 256'(rsp_err), 256'(e.err));
`endif
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("rsp_idle_data", 256'(rsp_data), 256'(0));
    end
    chk("pulses", 256'({start_core, core_clr, inst_clr, inst_wr_en}),
        256'({m_start, m_cclr, m_iclr, m_wen}));
    chk("config",
        {seq_test, ima_mux, imb_mux, am_num_predict, inst_wr_mode, inst_dbg_mode, inst_wr_addr,
         inst_wr_data, inst_rddbg_addr, loop_mode, loop_jump, loop_end, loop_count,
         slice_mode, slice_num_elem, observable},
        {m_seq, m_ima, m_imb, m_num, m_wrmode, m_dbg, m_waddr, m_wdata, m_rdbg, m_lmode,
         m_ljump, m_lend, m_lcount, m_smode, m_snum, m_obs});
  end

  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d, input logic w,
                     input logic r);
    req_valid = v; req_addr = a; req_data = d; req_write = w; rsp_ready = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    busy = 1'b1; cyc(1, 0, 0, 0, 1);
    busy = 1'b0; cyc(1, 0, 32'h2D, 1, 1); cyc(1, 0, 0, 0, 1);
    busy = 1'b1; cyc(1, 0, 32'h41, 1, 1); busy = 1'b0;
    cyc(1, 3, 32'h1, 1, 1); cyc(1, 4, 32'hFE, 1, 1);
    cyc(1, 5, 32'hA, 1, 1); cyc(1, 5, 32'hB, 1, 1); cyc(1, 5, 32'hC, 1, 1);
    cyc(1, 4, 0, 0, 1); cyc(1, 4, 0, 0, 1);
    cyc(1, 5, 32'hD, 1, 1); cyc(1, 4, 32'h10, 1, 1); cyc(0, 0, 0, 0, 1);
    cyc(1, 3, 32'h4, 1, 1); cyc(1, 5, 32'hE, 1, 1); cyc(1, 4, 0, 0, 1);
    am_valid = 1'b1; am_pred = 8'h05; cyc(0, 0, 0, 0, 1);
    am_valid = 1'b0; cyc(1, 2, 0, 0, 1); cyc(1, 2, 0, 0, 1);
    am_valid = 1'b1; am_pred = 8'h9A; cyc(1, 2, 0, 0, 1);
    am_valid = 1'b0; cyc(1, 2, 0, 0, 1);
    cyc(1, 15, 32'h12345678, 1, 1); cyc(1, 15, 0, 0, 1);
    repeat (3) cyc(1, 15, 32'hDEAD, 1, 0);
    cyc(1, 15, 32'hDEAD, 1, 1); cyc(1, 15, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    pc = 8'h3C; iat = 32'hCAFEF00D;
    cyc(1, 32'h20, 0, 0, 1); cyc(1, 7, 32'hFFFF, 1, 1); cyc(1, 7, 0, 0, 1);
    cyc(1, 8, 32'h1, 1, 1); cyc(1, 8, 0, 0, 1); cyc(1, 32'h20, 32'h5, 1, 1);
    cyc(1, 32'h8000_0003, 32'h7, 1, 1); cyc(1, 3, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      sel      = int'($urandom_range(0, 19));
      a        = (sel < 17) ? 32'($urandom_range(0, 15)) : ((sel < 19) ? 32'h20 : $urandom);
      busy     = 1'($urandom_range(0, 1));
      am_valid = ($urandom_range(0, 9) == 0);
      am_pred  = 8'($urandom);
      pc       = 8'($urandom);
      iat      = $urandom;
      cyc($urandom_range(0, 9) < 7, a, $urandom, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0);
    end

    repeat (3) cyc(0, 0, 0, 0, 1);
    chk("drain", 256'(exp_q.size()), 256'(0));

    cyc(1, 13, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    cyc(1, 13, 0, 0, 1); cyc(1, 4, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 1);
    chk("drain_after_reset", 256'(exp_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
